load_writeback: RTL and testbench
=================================

// Module: load_writeback
// PURPOSE
//  MEM/WB stage: registers the memory-stage control and result, then aligns and
//  sign/zero-extends the word returned by the 1-cycle-latency data BRAM for loads.
//  Downstream of memory_access, which issues the BRAM address; drives the
//  register-file write port and the WB forwarding path.
//  Holds load data internally across stalls, so BRAM output may change while WB is frozen.
// PARAMETERS
//  DATA_WIDTH      32  datapath / BRAM word width
//  RD_WIDTH        5   destination register index width
//  MEM_MODE_WIDTH  2   width of mem_mode (encodings `MEM_BYTE/`MEM_HWORD/`MEM_WORD, define.vh)
// PORTS
//  clk           in   1               stage clock
//  rst_n         in   1               asynchronous active-low reset
//  stall         in   1               1 = hold WB contents, ignore MEM inputs
//  flush         in   1               1 = kill WB entry at next edge (priority over stall)
//  mem_valid     in   1               MEM stage holds a real instruction
//  mem_read      in   1               load instruction (`MEM_RD_EN)
//  mem_mode      in   MEM_MODE_WIDTH  access size
//  mem_unsigned  in   1               1 = LBU/LHU zero-extend, 0 = sign-extend
//  mem_addr_lo   in   2               byte offset, mem_addr[1:0]
//  mem_alu_res   in   DATA_WIDTH      non-load result
//  mem_rd        in   RD_WIDTH        destination register
//  mem_reg_write in   1               instruction writes rd
//  dcache_rdata  in   DATA_WIDTH      BRAM read data, valid the cycle after address
//  wb_valid      out  1               WB entry valid
//  wb_reg_write  out  1               register-file write enable
//  wb_rd         out  RD_WIDTH        register-file write index
//  wb_data       out  DATA_WIDTH      register-file write data / forward value
//  wb_misalign   out  1               valid halfword load at offset 01/11
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=EMPTY; all stage regs, hold reg and all outputs 0.
//  - States: EMPTY (no entry), LIVE (entry, load data from dcache_rdata), HELD (entry,
//    load data from hold reg). On each rising edge:
//    flush=1 -> EMPTY. Else if stall=1: LIVE -> HELD, capture aligned load data into
//    the hold reg; HELD -> HELD; EMPTY -> EMPTY. Else (stall=0): capture all mem_*
//    inputs; state=LIVE if mem_valid else EMPTY.
//  - Latency: mem_* at cycle N -> wb_* valid in cycle N+1. Alignment uses same-cycle
//    dcache_rdata (combinational from input to wb_data in LIVE).
//  - wb_valid = (state!=EMPTY). wb_reg_write = wb_valid & reg_write & (rd!=0).
//    wb_rd = registered rd. Outputs are 0 when EMPTY.
//  - wb_data, non-load: registered alu_res. Load, from rdata (LIVE) or hold reg (HELD):
//    BYTE: byte[off], bits 7:0 of rdata>>(8*off); bit 7 extended unless unsigned.
//    HWORD: off 00 -> bits 15:0, off 10 -> bits 31:16, extended from bit 15;
//    off 01/11 -> 0, wb_misalign=1 (write still performed, value 0).
//    WORD: full rdata, offset ignored. Undefined mode encoding -> 0.
//  - wb_misalign = 0 except the case above; follows the entry through stall.
//  - stall and flush together -> flush wins. Reset mid-stall -> EMPTY, hold reg cleared.
//  - Non-load entries never consult dcache_rdata; HELD transition harmless for them.
// TESTING
//  LB off 11, rdata=32'h80FF_1234, signed -> wb_data=32'hFFFF_FF80, wb_reg_write=1 at N+1.
//  LHU off 10, rdata=32'h8001_7FFF -> 32'h0000_8001; LH off 00 same rdata -> 32'h0000_7FFF.
//  LW rdata=32'hDEAD_BEEF, stall 3 cycles, rdata changes to 0 from cycle N+2 ->
//    wb_data stays 32'hDEAD_BEEF all 4 cycles; single register write after release.
//  LH off 01 -> wb_data=0, wb_misalign=1; ALU op with rd=0 -> wb_reg_write=0.
//  stall=1 & flush=1 on a valid entry -> wb_valid=0 next cycle; rst_n low mid-HELD ->
//    all outputs 0 immediately (async), wb_valid=0 after release until new mem_valid.

Source files
------------

// File: rtl/load_writeback.sv
// MEM/WB pipeline stage: registers memory-stage results and aligns/extends BRAM load data.
// Load data is latched internally on stall so the BRAM output may change while WB is frozen.
module load_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int RD_WIDTH       = 5,
    parameter int MEM_MODE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic                      mem_read,
    input  logic [MEM_MODE_WIDTH-1:0] mem_mode,
    input  logic                      mem_unsigned,
    input  logic [1:0]                mem_addr_lo,
    input  logic [DATA_WIDTH-1:0]     mem_alu_res,
    input  logic [RD_WIDTH-1:0]       mem_rd,
    input  logic                      mem_reg_write,
    input  logic [DATA_WIDTH-1:0]     dcache_rdata,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic [RD_WIDTH-1:0]       wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_misalign
);

    // state    | meaning
    // ST_EMPTY | no instruction in WB
    // ST_LIVE  | entry valid, load data taken from dcache_rdata this cycle
    // ST_HELD  | entry valid and stalled, load data taken from r_hold
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LIVE  = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [MEM_MODE_WIDTH-1:0] MEM_BYTE  = MEM_MODE_WIDTH'(0);
    localparam logic [MEM_MODE_WIDTH-1:0] MEM_HWORD = MEM_MODE_WIDTH'(1);
    localparam logic [MEM_MODE_WIDTH-1:0] MEM_WORD  = MEM_MODE_WIDTH'(2);

    state_t                    r_state;
    logic                      r_read;
    logic [MEM_MODE_WIDTH-1:0] r_mode;
    logic                      r_unsigned;
    logic [1:0]                r_off;
    logic [DATA_WIDTH-1:0]     r_alu_res;
    logic [RD_WIDTH-1:0]       r_rd;
    logic                      r_reg_write;
    logic [DATA_WIDTH-1:0]     r_hold;

    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [DATA_WIDTH-1:0]     w_aligned;
    logic                      w_valid;

    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = dcache_rdata[7:0];
            2'd1: w_byte = dcache_rdata[15:8];
            2'd2: w_byte = dcache_rdata[23:16];
            2'd3: w_byte = dcache_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];

        w_aligned = '0;
        case (r_mode)
            MEM_BYTE:  w_aligned = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
            MEM_HWORD: w_aligned = r_off[0] ? '0
                                 : {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
            MEM_WORD:  w_aligned = dcache_rdata;
            default:   w_aligned = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_read      <= 1'b0;
            r_mode      <= '0;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_alu_res   <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_hold      <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (stall) begin
            // Only the first stalled cycle samples the BRAM; later cycles keep the copy.
            if (r_state == ST_LIVE) begin
                r_state <= ST_HELD;
                r_hold  <= w_aligned;
            end
        end else begin
            r_state     <= mem_valid ? ST_LIVE : ST_EMPTY;
            r_read      <= mem_read;
            r_mode      <= mem_mode;
            r_unsigned  <= mem_unsigned;
            r_off       <= mem_addr_lo;
            r_alu_res   <= mem_alu_res;
            r_rd        <= mem_rd;
            r_reg_write <= mem_reg_write;
        end
    end

    assign w_valid      = (r_state != ST_EMPTY);
    assign wb_valid     = w_valid;
    assign wb_reg_write = w_valid & r_reg_write & (r_rd != '0);
    assign wb_rd        = w_valid ? r_rd : '0;
    assign wb_misalign  = w_valid & r_read & (r_mode == MEM_HWORD) & r_off[0];

    always_comb begin
        wb_data = '0;
        if (w_valid) begin
            if (!r_read)
                wb_data = r_alu_res;
            else if (r_state == ST_HELD)
                wb_data = r_hold;
            else
                wb_data = w_aligned;
        end
    end

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed scenarios plus random traffic
// compared against a behavioural model of the WB entry.
module tb_load_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  mem_mode = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [1:0]  mem_addr_lo = 2'd0;
    logic [31:0] mem_alu_res = 32'd0;
    logic [4:0]  mem_rd = 5'd0;
    logic        mem_reg_write = 1'b0;
    logic [31:0] dcache_rdata = 32'd0;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_misalign;

    int checks = 0;
    int failures = 0;

    load_writeback #(.DATA_WIDTH(32), .RD_WIDTH(5), .MEM_MODE_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_mode(mem_mode),
        .mem_unsigned(mem_unsigned), .mem_addr_lo(mem_addr_lo),
        .mem_alu_res(mem_alu_res), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .dcache_rdata(dcache_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          held;
        bit          read;
        bit [1:0]    mode;
        bit          uns;
        bit [1:0]    off;
        bit [31:0]   alu;
        bit [4:0]    rd;
        bit          rw;
        bit [31:0]   hold;
    } entry_t;

    // Load value from a memory word, computed straight from the size/offset rules.
    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] mode,
                                             input logic uns, input logic [1:0] off);
        logic [31:0] v;
        v = 32'd0;
        if (mode == 2'd0) begin
            v = (word >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (mode == 2'd1) begin
            if (off == 2'd0) v = word & 32'h0000_FFFF;
            else if (off == 2'd2) v = word >> 16;
            else v = 32'd0;
            if (off[0] == 1'b0 && !uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else if (mode == 2'd2) begin
            v = word;
        end
        return v;
    endfunction

    task automatic drive_mem(input logic v, input logic rd_en, input logic [1:0] mode,
                             input logic uns, input logic [1:0] off, input logic [31:0] alu,
                             input logic [4:0] rd, input logic rw);
        mem_valid = v; mem_read = rd_en; mem_mode = mode; mem_unsigned = uns;
        mem_addr_lo = off; mem_alu_res = alu; mem_rd = rd; mem_reg_write = rw;
    endtask

    task automatic idle();
        drive_mem(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_mem(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'h1234, 5'd3, 1'b1);
        dcache_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", wb_reg_write); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wb_data); end
        checks++; if (wb_misalign !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", wb_misalign); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lb();
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd0, 1'b0, 2'd3, 32'h5555, 5'd5, 1'b1);
        @(negedge clk);
        idle();
        dcache_rdata = 32'h80FF_1234;
        #1;
        checks++; if (wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", wb_data); end
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL lb_rw got=%b exp=1", wb_reg_write); end
        checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL lb_rd got=%0d exp=5", wb_rd); end
        checks++; if (wb_misalign !== 1'b0) begin failures++; $display("FAIL lb_mis got=%b exp=0", wb_misalign); end
    endtask

    task automatic test_halfword();
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 32'd0, 5'd6, 1'b1);
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 32'd0, 5'd7, 1'b1);
        dcache_rdata = 32'h8001_7FFF;
        #1;
        checks++; if (wb_data !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", wb_data); end
        checks++; if (wb_rd !== 5'd6) begin failures++; $display("FAIL lhu_rd got=%0d exp=6", wb_rd); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (wb_data !== 32'h0000_7FFF) begin failures++; $display("FAIL lh_data got=%h exp=00007fff", wb_data); end
        checks++; if (wb_rd !== 5'd7) begin failures++; $display("FAIL lh_rd got=%0d exp=7", wb_rd); end
    endtask

    task automatic test_stall_hold();
        int writes;
        writes = 0;
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd2, 1'b0, 2'd1, 32'd0, 5'd9, 1'b1);
        @(negedge clk);
        idle();
        dcache_rdata = 32'hDEAD_BEEF;
        stall = 1'b1;
        #1;
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_live got=%h exp=deadbeef", wb_data); end
        if (wb_reg_write && !stall) writes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dcache_rdata = 32'd0;
            stall = (i < 2);
            #1;
            checks++; if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_held[%0d] got=%h exp=deadbeef", i, wb_data); end
            checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL lw_held_valid[%0d] got=%b exp=1", i, wb_valid); end
            if (wb_reg_write && !stall) writes++;
        end
        checks++; if (writes != 1) begin failures++; $display("FAIL lw_writes got=%0d exp=1", writes); end
        @(negedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL lw_drain got=%b exp=0", wb_valid); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 32'd0, 5'd10, 1'b1);
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 32'hCAFE_0001, 5'd0, 1'b1);
        dcache_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL mis_data got=%h exp=0", wb_data); end
        checks++; if (wb_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", wb_misalign); end
        checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL mis_rw got=%b exp=1", wb_reg_write); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL rd0_rw got=%b exp=0", wb_reg_write); end
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL rd0_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_data !== 32'hCAFE_0001) begin failures++; $display("FAIL rd0_data got=%h exp=cafe0001", wb_data); end
        checks++; if (wb_misalign !== 1'b0) begin failures++; $display("FAIL rd0_mis got=%b exp=0", wb_misalign); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 5'd11, 1'b1);
        @(negedge clk);
        idle();
        stall = 1'b1;
        flush = 1'b1;
        dcache_rdata = 32'd1;
        #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", wb_valid); end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL flush_data got=%h exp=0", wb_data); end
    endtask

    task automatic test_reset_mid_held();
        @(negedge clk);
        drive_mem(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 5'd12, 1'b1);
        @(negedge clk);
        idle();
        stall = 1'b1;
        dcache_rdata = 32'h1234_5678;
        @(negedge clk);
        dcache_rdata = 32'd0;
        #1;
        checks++; if (wb_data !== 32'h1234_5678) begin failures++; $display("FAIL rsth_pre got=%h exp=12345678", wb_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rsth_valid got=%b exp=0", wb_valid); end
        checks++; if (wb_data !== 32'd0) begin failures++; $display("FAIL rsth_data got=%h exp=0", wb_data); end
        checks++; if (wb_reg_write !== 1'b0) begin failures++; $display("FAIL rsth_rw got=%b exp=0", wb_reg_write); end
        checks++; if (wb_rd !== 5'd0) begin failures++; $display("FAIL rsth_rd got=%0d exp=0", wb_rd); end
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rsth_post got=%b exp=0", wb_valid); end
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'd77, 5'd13, 1'b1);
        @(negedge clk);
        idle();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd77) begin failures++; $display("FAIL rsth_new got=%b/%h exp=1/0000004d", wb_valid, wb_data); end
    endtask

    task automatic test_random();
        entry_t m;
        logic [31:0] e_data;
        logic        e_rw, e_mis;
        logic [4:0]  e_rd;
        m = '{default: 0};
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            stall = ($urandom_range(3, 0) == 0);
            flush = ($urandom_range(15, 0) == 0);
            drive_mem(1'($urandom), 1'($urandom), 2'($urandom_range(3, 0)), 1'($urandom),
                      2'($urandom), $urandom, 5'($urandom), 1'($urandom));
            dcache_rdata = $urandom;
            #1;
            e_data = 32'd0; e_rw = 1'b0; e_mis = 1'b0; e_rd = 5'd0;
            if (m.valid) begin
                e_rd  = m.rd;
                e_rw  = m.rw && (m.rd != 5'd0);
                e_mis = m.read && (m.mode == 2'd1) && m.off[0];
                if (!m.read) e_data = m.alu;
                else if (m.held) e_data = m.hold;
                else e_data = exp_load(dcache_rdata, m.mode, m.uns, m.off);
            end
            checks++; if (wb_valid !== m.valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, wb_valid, m.valid); end
            checks++; if (wb_data !== e_data) begin failures++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, wb_data, e_data); end
            checks++; if (wb_reg_write !== e_rw) begin failures++; $display("FAIL rnd_rw c=%0d got=%b exp=%b", c, wb_reg_write, e_rw); end
            checks++; if (wb_rd !== e_rd) begin failures++; $display("FAIL rnd_rd c=%0d got=%0d exp=%0d", c, wb_rd, e_rd); end
            checks++; if (wb_misalign !== e_mis) begin failures++; $display("FAIL rnd_mis c=%0d got=%b exp=%b", c, wb_misalign, e_mis); end
            if (flush) begin
                m.valid = 1'b0;
            end else if (stall) begin
                if (m.valid && !m.held) begin
                    m.held = 1'b1;
                    m.hold = exp_load(dcache_rdata, m.mode, m.uns, m.off);
                end
            end else begin
                m.valid = mem_valid; m.held = 1'b0; m.read = mem_read; m.mode = mem_mode;
                m.uns = mem_unsigned; m.off = mem_addr_lo; m.alu = mem_alu_res;
                m.rd = mem_rd; m.rw = mem_reg_write;
            end
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_lb();
        test_halfword();
        test_stall_hold();
        test_misalign();
        test_flush();
        test_reset_mid_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
